fnd_scan_4dig: RTL and testbench

- Downstream display stage for the watch counters.
- Takes two 6-bit count values (minutes and seconds, 0..59 nominal) and the seconds-counter half-period carry, and drives a 4-digit common-anode 7-segment display by time-multiplexing.
- Converts binary to BCD, scans digits at a programmable rate, and inserts a ghosting blank interval between digits.

---
 rtl/fnd_pkg.sv | 39 +++
 rtl/fnd_scan_4dig_bin2bcd_6.sv | 34 +++
 rtl/fnd_scan_4dig.sv | 142 ++++++++++++++
 tb/tb_fnd_scan_4dig.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment display.
// Segment codes are active-low, bit order g,f,e,d,c,b,a.
package fnd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // All digit commons off (active-low commons)
    localparam logic [3:0] COM_OFF = 4'hF;

    // Digit position; DIG0 is the rightmost digit
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } dig_idx_t;

    // Decimal digit to segment pattern; non-decimal inputs show blank
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        seg_code = SEG_BLANK;
        if (d <= 4'd9) begin
            seg_code = SEG_LUT[d];
        end
    endfunction

endpackage

// File: rtl/fnd_scan_4dig_bin2bcd_6.sv
// bin2bcd_6: combinational 6-bit binary to two BCD digits (tens 0..6, ones 0..9).
module bin2bcd_6 (
    input  logic [5:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    // Constant-compare ladder; ones is formed in 4-bit modular arithmetic,
    // which is exact because the true remainder is always below 10.
    always_comb begin
        tens_o = '0;
        ones_o = bin_i[3:0];
        if (bin_i >= 6'd60) begin
            tens_o = 4'd6;
            ones_o = bin_i[3:0] - 4'(6'd60);
        end else if (bin_i >= 6'd50) begin
            tens_o = 4'd5;
            ones_o = bin_i[3:0] - 4'(6'd50);
        end else if (bin_i >= 6'd40) begin
            tens_o = 4'd4;
            ones_o = bin_i[3:0] - 4'(6'd40);
        end else if (bin_i >= 6'd30) begin
            tens_o = 4'd3;
            ones_o = bin_i[3:0] - 4'(6'd30);
        end else if (bin_i >= 6'd20) begin
            tens_o = 4'd2;
            ones_o = bin_i[3:0] - 4'(6'd20);
        end else if (bin_i >= 6'd10) begin
            tens_o = 4'd1;
            ones_o = bin_i[3:0] - 4'(6'd10);
        end
    end

endmodule

// File: rtl/fnd_scan_4dig.sv
// fnd_scan_4dig: scans minutes/seconds onto a 4-digit common-anode display
// with per-digit blanking and a coherent per-frame snapshot of the values.
// Optional macro FND_LZB_EN: blank the leading (minutes tens) digit when zero.
module fnd_scan_4dig
    import fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       en,
    input  logic [5:0] val_lo,
    input  logic [5:0] val_hi,
    input  logic       dp_in,
    output logic [7:0] seg_o,
    output logic [3:0] com_o
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYC);

    logic [PW-1:0] presc_q, presc_d;
    dig_idx_t      idx_q, idx_d;
    logic          en_q, en_d;
    logic [5:0]    sh_lo_q, sh_lo_d;
    logic [5:0]    sh_hi_q, sh_hi_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    com_q, com_d;

    logic          tick;
    logic          en_rise;
    logic [5:0]    sel_lo, sel_hi;
    logic [3:0]    lo_tens, lo_ones, hi_tens, hi_ones;

    assign tick    = (presc_q == PRESC_LAST);
    assign en_rise = en & ~en_q;

    // The first enabled cycle captures the live values; they feed the output
    // directly so the opening blank interval already carries the new digit.
    assign sel_lo = en_rise ? val_lo : sh_lo_q;
    assign sel_hi = en_rise ? val_hi : sh_hi_q;

    bin2bcd_6 u_bcd_lo (
        .bin_i  (sel_lo),
        .tens_o (lo_tens),
        .ones_o (lo_ones)
    );

    bin2bcd_6 u_bcd_hi (
        .bin_i  (sel_hi),
        .tens_o (hi_tens),
        .ones_o (hi_ones)
    );

    // State registers: prescaler, digit index, enable history, snapshot, outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= DIG0;
            en_q    <= 1'b0;
            sh_lo_q <= '0;
            sh_hi_q <= '0;
            seg_q   <= '1;
            com_q   <= COM_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            sh_lo_q <= sh_lo_d;
            sh_hi_q <= sh_hi_d;
            seg_q   <= seg_d;
            com_q   <= com_d;
        end
    end

    // Scan sequencing: prescaler wrap advances the digit; snapshot per frame
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        en_d    = en;
        sh_lo_d = sh_lo_q;
        sh_hi_d = sh_hi_q;
        if (!en) begin
            presc_d = '0;
            idx_d   = DIG0;
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                case (idx_q)
                    DIG0: idx_d = DIG1;
                    DIG1: idx_d = DIG2;
                    DIG2: idx_d = DIG3;
                    DIG3: idx_d = DIG0;
                endcase
            end
            if ((tick && idx_q == DIG3) || en_rise) begin
                sh_lo_d = val_lo;
                sh_hi_d = val_hi;
            end
        end
    end

    // Next output pattern for the current digit slot, blanked at slot start
    always_comb begin
        seg_d = {1'b1, SEG_BLANK};
        com_d = COM_OFF;
        if (en) begin
            case (idx_q)
                DIG0: begin
                    seg_d[6:0] = seg_code(lo_ones);
                    com_d      = 4'b1110;
                end
                DIG1: begin
                    seg_d[6:0] = seg_code(lo_tens);
                    com_d      = 4'b1101;
                end
                DIG2: begin
                    seg_d[6:0] = seg_code(hi_ones);
                    seg_d[7]   = ~dp_in;
                    com_d      = 4'b1011;
                end
                DIG3: begin
`ifdef FND_LZB_EN
                    seg_d[6:0] = (hi_tens == 4'd0) ? SEG_BLANK : seg_code(hi_tens);
`else
                    seg_d[6:0] = seg_code(hi_tens);
`endif
                    com_d      = 4'b0111;
                end
            endcase
            if (presc_q < PRESC_BLANK) begin
                com_d = COM_OFF;
            end
        end
    end

    assign seg_o = seg_q;
    assign com_o = com_q;

endmodule

// File: tb/tb_fnd_scan_4dig.sv
// Self-checking bench for fnd_scan_4dig (SCAN_DIV=8, BLANK_CYC=2).
// Expected outputs come from a frame/slot arithmetic model of the display.
module tb_fnd_scan_4dig;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * SD;

    logic       rst, clk, en, dp_in;
    logic [5:0] val_lo, val_hi;
    logic [7:0] seg_o;
    logic [3:0] com_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [6:0] seg_tab [0:9];
    int         t;
    int         snap_lo, snap_hi;
    logic [7:0] exp_seg;
    logic [3:0] exp_com;

    fnd_scan_4dig #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .rst    (rst),
        .clk    (clk),
        .en     (en),
        .val_lo (val_lo),
        .val_hi (val_hi),
        .dp_in  (dp_in),
        .seg_o  (seg_o),
        .com_o  (com_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model over one rising edge, then settle 1 time unit.
    // t counts enabled cycles since the display (re)started; -1 = dark.
    task automatic model_step();
        int slot, phase, digit;
        logic [6:0] code;
        logic dp;
        @(posedge clk);
        if (!rst || !en) begin
            t = -1;
            exp_seg = 8'hFF;
            exp_com = 4'hF;
        end else begin
            t = t + 1;
            if (t == 0) begin
                snap_lo = int'(val_lo);
                snap_hi = int'(val_hi);
            end
            slot  = (t / SD) % 4;
            phase = t % SD;
            case (slot)
                0:       digit = snap_lo % 10;
                1:       digit = snap_lo / 10;
                2:       digit = snap_hi % 10;
                default: digit = snap_hi / 10;
            endcase
            code = seg_tab[digit];
`ifdef FND_LZB_EN
            if (slot == 3 && snap_hi < 10) code = 7'b1111111;
`endif
            dp = (slot == 2) ? ~dp_in : 1'b1;
            exp_seg = {dp, code};
            exp_com = (phase < BC) ? 4'hF : 4'(~(4'b0001 << slot));
            // Last cycle of a frame: next frame uses values present now
            if ((t + 1) % FRAME == 0) begin
                snap_lo = int'(val_lo);
                snap_hi = int'(val_hi);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; dp_in = 1'b1; val_lo = 6'd34; val_hi = 6'd12;
        for (int i = 0; i < 3; i++) begin
            model_step();
            n_checks++;
            if (seg_o !== 8'hFF || com_o !== 4'hF) begin
                n_fail++;
                $display("FAIL reset cyc=%0d seg=%b com=%b required seg=11111111 com=1111", i, seg_o, com_o);
            end
        end
    endtask

    task automatic test_scan_basic();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; val_hi = 6'd12; val_lo = 6'd34; dp_in = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            model_step();
            n_checks++;
            if (seg_o !== exp_seg || com_o !== exp_com) begin
                n_fail++;
                $display("FAIL scan_basic t=%0d seg=%b com=%b required seg=%b com=%b", t, seg_o, com_o, exp_seg, exp_com);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_frame_update();
        int guard = 0;
        // Run into the tens-of-seconds slot of a frame
        while (!(t >= 0 && t % FRAME == SD + 2) && guard < 2 * FRAME) begin
            model_step();
            n_checks++;
            if (seg_o !== exp_seg || com_o !== exp_com) begin
                n_fail++;
                $display("FAIL mid_frame_align t=%0d seg=%b com=%b required seg=%b com=%b", t, seg_o, com_o, exp_seg, exp_com);
            end
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 2 * FRAME) begin
            n_fail++;
            $display("FAIL mid_frame_align_timeout guard=%0d required <%0d", guard, 2 * FRAME);
        end
        val_lo = 6'd35;
        for (int i = 0; i < 2 * FRAME; i++) begin
            model_step();
            n_checks++;
            if (seg_o !== exp_seg || com_o !== exp_com) begin
                n_fail++;
                $display("FAIL mid_frame t=%0d seg=%b com=%b required seg=%b com=%b", t, seg_o, com_o, exp_seg, exp_com);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_values(input logic [5:0] hi, input logic [5:0] lo);
        val_hi = hi; val_lo = lo;
        for (int i = 0; i < 2 * FRAME; i++) begin
            dp_in = 1'($urandom_range(0, 1));
            model_step();
            n_checks++;
            if (seg_o !== exp_seg || com_o !== exp_com) begin
                n_fail++;
                $display("FAIL values hi=%0d lo=%0d t=%0d seg=%b com=%b required seg=%b com=%b", hi, lo, t, seg_o, com_o, exp_seg, exp_com);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_en_drop();
        int guard = 0;
        // Run into the minutes-ones slot, past its blank interval
        while (!(t >= 0 && t % FRAME == 2 * SD + 3) && guard < 2 * FRAME) begin
            model_step();
            n_checks++;
            if (seg_o !== exp_seg || com_o !== exp_com) begin
                n_fail++;
                $display("FAIL en_drop_align t=%0d seg=%b com=%b required seg=%b com=%b", t, seg_o, com_o, exp_seg, exp_com);
            end
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 2 * FRAME) begin
            n_fail++;
            $display("FAIL en_drop_align_timeout guard=%0d required <%0d", guard, 2 * FRAME);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            model_step();
            n_checks++;
            if (seg_o !== 8'hFF || com_o !== 4'hF) begin
                n_fail++;
                $display("FAIL en_low cyc=%0d seg=%b com=%b required seg=11111111 com=1111", i, seg_o, com_o);
            end
            @(negedge clk);
        end
        en = 1'b1;
        val_hi = 6'($urandom_range(0, 63));
        val_lo = 6'($urandom_range(0, 63));
        for (int i = 0; i < FRAME + 8; i++) begin
            model_step();
            n_checks++;
            if (seg_o !== exp_seg || com_o !== exp_com) begin
                n_fail++;
                $display("FAIL en_resume t=%0d seg=%b com=%b required seg=%b com=%b", t, seg_o, com_o, exp_seg, exp_com);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < SD + 3; i++) begin
            model_step();
            n_checks++;
            if (seg_o !== exp_seg || com_o !== exp_com) begin
                n_fail++;
                $display("FAIL areset_pre t=%0d seg=%b com=%b required seg=%b com=%b", t, seg_o, com_o, exp_seg, exp_com);
            end
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (seg_o !== 8'hFF || com_o !== 4'hF) begin
            n_fail++;
            $display("FAIL areset_immediate seg=%b com=%b required seg=11111111 com=1111", seg_o, com_o);
        end
        for (int i = 0; i < 2; i++) begin
            model_step();
            n_checks++;
            if (seg_o !== exp_seg || com_o !== exp_com) begin
                n_fail++;
                $display("FAIL areset_hold seg=%b com=%b required seg=%b com=%b", seg_o, com_o, exp_seg, exp_com);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        val_hi = 6'd47; val_lo = 6'd58;
        for (int i = 0; i < FRAME + 4; i++) begin
            model_step();
            n_checks++;
            if (seg_o !== exp_seg || com_o !== exp_com) begin
                n_fail++;
                $display("FAIL areset_after t=%0d seg=%b com=%b required seg=%b com=%b", t, seg_o, com_o, exp_seg, exp_com);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) val_lo = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 11) == 0) val_hi = 6'($urandom_range(0, 63));
            dp_in = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 29) != 0);
            model_step();
            n_checks++;
            if (seg_o !== exp_seg || com_o !== exp_com) begin
                n_fail++;
                $display("FAIL random t=%0d seg=%b com=%b required seg=%b com=%b", t, seg_o, com_o, exp_seg, exp_com);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
        t = -1; snap_lo = 0; snap_hi = 0;
        exp_seg = 8'hFF; exp_com = 4'hF;

        test_reset();
        test_scan_basic();
        test_mid_frame_update();
        test_values(6'd0, 6'd7);
        test_values(6'd63, 6'd60);
        test_values(6'd59, 6'd9);
        test_en_drop();
        test_async_reset();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
